deal_seq_ctrl: RTL and testbench

DEAL_SEQ_CTRL -- requirements
Module: deal_seq_ctrl

---
 rtl/deal_seq_ctrl_pkg.sv | 27 ++
 rtl/deal_seq_arbiter.sv | 43 ++++
 rtl/deal_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_deal_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deal_seq_ctrl_pkg.sv
// Shared definitions for the card-deal sequencer: FSM state encodings,
// hand destinations, default deck/latency parameters and the dealt-counter helper.
package deal_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INIT_REQ  = 3'd1,
      ST_INIT_WAIT = 3'd2,
      ST_READY     = 3'd3,
      ST_HIT_REQ   = 3'd4,
      ST_HIT_WAIT  = 3'd5,
      ST_EMPTY     = 3'd6
   } deal_state_e;

   localparam logic DEST_PLAYER   = 1'b0;
   localparam logic DEST_DEALER   = 1'b1;

   localparam int   DEF_DECK_SIZE = 52;
   localparam int   DEF_CARD_LAT  = 2;
   localparam int   DEALT_W       = 6;

   // Dealt counter sticks at all-ones instead of wrapping.
   function automatic logic [DEALT_W-1:0] sat_inc(input logic [DEALT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/deal_seq_arbiter.sv
// Two-requester hit arbiter (player/dealer). DEAL_SEQ_RR_ARB_EN selects
// round-robin tie-breaking; otherwise the player always wins a tie.
module deal_seq_arbiter
   import deal_seq_ctrl_pkg::*;
(
   input  logic clk_ctrl_i,
   input  logic rst_ctrl_i,
   input  logic player_req_i,
   input  logic dealer_req_i,
   input  logic accept_i,
   output logic grant_o,
   output logic grant_dest_o
);

   assign grant_o = player_req_i | dealer_req_i;

`ifdef DEAL_SEQ_RR_ARB_EN
   logic prio_reg;

   // The side just served drops to low priority for the next tie.
   always_ff @(posedge clk_ctrl_i or negedge rst_ctrl_i) begin
      if (!rst_ctrl_i) begin
         prio_reg <= DEST_PLAYER;
      end else if (accept_i && grant_o) begin
         prio_reg <= ~grant_dest_o;
      end
   end

   always_comb begin
      grant_dest_o = DEST_PLAYER;
      if (player_req_i && dealer_req_i) begin
         grant_dest_o = prio_reg;
      end else if (dealer_req_i) begin
         grant_dest_o = DEST_DEALER;
      end
   end
`else
   logic unused_arb;
   assign unused_arb   = clk_ctrl_i ^ rst_ctrl_i ^ accept_i;
   assign grant_dest_o = (dealer_req_i && !player_req_i) ? DEST_DEALER : DEST_PLAYER;
`endif

endmodule

// File: rtl/deal_seq_ctrl.sv
// Blackjack deal sequencer: initial 4-card deal, player/dealer hits, deck exhaustion.
// Build with DEAL_SEQ_RR_ARB_EN defined for round-robin hit arbitration.
module deal_seq_ctrl
   import deal_seq_ctrl_pkg::*;
#(
   parameter int CARD_LAT  = DEF_CARD_LAT,
   parameter int DECK_SIZE = DEF_DECK_SIZE
)(
   input  logic       clk_ctrl_i,
   input  logic       rst_ctrl_i,
   input  logic       start_deal_i,
   input  logic       player_hit_i,
   input  logic       dealer_hit_i,
   input  logic [7:0] card_dp_i,
   output logic       req_card_dp_o,
   output logic [7:0] card_o,
   output logic       card_valid_o,
   output logic       card_dest_o,
   output logic       player_ack_o,
   output logic       dealer_ack_o,
   output logic       busy_o,
   output logic       deal_done_o,
   output logic       deck_empty_o
);

   localparam int                 WAIT_W     = (CARD_LAT > 1) ? $clog2(CARD_LAT) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(CARD_LAT - 1);
   localparam logic [DEALT_W-1:0] DECK_LIMIT = DEALT_W'(DECK_SIZE);

   deal_state_e        state_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   logic [1:0]         init_idx_reg;
   logic [DEALT_W-1:0] dealt_cnt_reg;
   logic               hit_dest_reg;
   logic               req_reg;
   logic [7:0]         card_reg;
   logic               valid_reg;
   logic               card_dest_reg;
   logic               player_ack_reg;
   logic               dealer_ack_reg;
   logic               done_reg;
   logic               empty_reg;

   logic               arb_accept;
   logic               arb_grant;
   logic               arb_dest;
   logic               deck_out;

   assign arb_accept = (state_reg == ST_READY) && !start_deal_i;
   assign deck_out   = (dealt_cnt_reg >= DECK_LIMIT);

   deal_seq_arbiter u_arbiter (
      .clk_ctrl_i   (clk_ctrl_i),
      .rst_ctrl_i   (rst_ctrl_i),
      .player_req_i (player_hit_i),
      .dealer_req_i (dealer_hit_i),
      .accept_i     (arb_accept),
      .grant_o      (arb_grant),
      .grant_dest_o (arb_dest)
   );

   always_ff @(posedge clk_ctrl_i or negedge rst_ctrl_i) begin
      if (!rst_ctrl_i) begin
         state_reg      <= ST_IDLE;
         wait_cnt_reg   <= '0;
         init_idx_reg   <= '0;
         dealt_cnt_reg  <= '0;
         hit_dest_reg   <= DEST_PLAYER;
         req_reg        <= 1'b0;
         card_reg       <= '0;
         valid_reg      <= 1'b0;
         card_dest_reg  <= DEST_PLAYER;
         player_ack_reg <= 1'b0;
         dealer_ack_reg <= 1'b0;
         done_reg       <= 1'b0;
         empty_reg      <= 1'b0;
      end else begin
         req_reg        <= 1'b0;
         valid_reg      <= 1'b0;
         player_ack_reg <= 1'b0;
         dealer_ack_reg <= 1'b0;
         done_reg       <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (start_deal_i) begin
                  state_reg    <= ST_INIT_REQ;
                  init_idx_reg <= '0;
                  req_reg      <= 1'b1;
               end
            end

            ST_INIT_REQ, ST_HIT_REQ: begin
               dealt_cnt_reg <= sat_inc(dealt_cnt_reg);
               wait_cnt_reg  <= WAIT_LAST;
               state_reg     <= (state_reg == ST_INIT_REQ) ? ST_INIT_WAIT : ST_HIT_WAIT;
            end

            // Initial deal alternates player/dealer on the low index bit.
            ST_INIT_WAIT: begin
               if (wait_cnt_reg != '0) begin
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               end else begin
                  card_reg      <= card_dp_i;
                  valid_reg     <= 1'b1;
                  card_dest_reg <= init_idx_reg[0];
                  if (deck_out) begin
                     state_reg <= ST_EMPTY;
                     empty_reg <= 1'b1;
                  end else if (init_idx_reg == 2'd3) begin
                     state_reg <= ST_READY;
                     done_reg  <= 1'b1;
                  end else begin
                     init_idx_reg <= init_idx_reg + 2'd1;
                     state_reg    <= ST_INIT_REQ;
                     req_reg      <= 1'b1;
                  end
               end
            end

            ST_READY: begin
               if (start_deal_i) begin
                  state_reg    <= ST_INIT_REQ;
                  init_idx_reg <= '0;
                  req_reg      <= 1'b1;
               end else if (arb_grant) begin
                  state_reg    <= ST_HIT_REQ;
                  hit_dest_reg <= arb_dest;
                  req_reg      <= 1'b1;
               end
            end

            ST_HIT_WAIT: begin
               if (wait_cnt_reg != '0) begin
                  wait_cnt_reg <= wait_cnt_reg - 1'b1;
               end else begin
                  card_reg       <= card_dp_i;
                  valid_reg      <= 1'b1;
                  card_dest_reg  <= hit_dest_reg;
                  player_ack_reg <= (hit_dest_reg == DEST_PLAYER);
                  dealer_ack_reg <= (hit_dest_reg == DEST_DEALER);
                  if (deck_out) begin
                     state_reg <= ST_EMPTY;
                     empty_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_READY;
                  end
               end
            end

            ST_EMPTY: begin
               state_reg <= ST_EMPTY;
            end

            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_card_dp_o = req_reg;
   assign card_o        = card_reg;
   assign card_valid_o  = valid_reg;
   assign card_dest_o   = card_dest_reg;
   assign player_ack_o  = player_ack_reg;
   assign dealer_ack_o  = dealer_ack_reg;
   assign deal_done_o   = done_reg;
   assign deck_empty_o  = empty_reg;
   assign busy_o        = (state_reg != ST_IDLE) && (state_reg != ST_READY) &&
                          (state_reg != ST_EMPTY);

endmodule

// File: tb/tb_deal_seq_ctrl.sv
// Directed bench for deal_seq_ctrl (CARD_LAT=2, DECK_SIZE=6) with a fixed-latency deck stub.
module tb_deal_seq_ctrl;

   localparam int CARD_LAT  = 2;
   localparam int DECK_SIZE = 6;
`ifdef DEAL_SEQ_RR_ARB_EN
   localparam logic [2:0] TIE2_FLAGS = 3'b101;
`else
   localparam logic [2:0] TIE2_FLAGS = 3'b010;
`endif

   logic       clk_ctrl_i   = 1'b0;
   logic       rst_ctrl_i   = 1'b1;
   logic       start_deal_i = 1'b0;
   logic       player_hit_i = 1'b0;
   logic       dealer_hit_i = 1'b0;
   logic [7:0] card_dp_i    = 8'hEE;
   logic       req_card_dp_o;
   logic [7:0] card_o;
   logic       card_valid_o;
   logic       card_dest_o;
   logic       player_ack_o;
   logic       dealer_ack_o;
   logic       busy_o;
   logic       deal_done_o;
   logic       deck_empty_o;

   always #5 clk_ctrl_i = ~clk_ctrl_i;

   deal_seq_ctrl #(.CARD_LAT(CARD_LAT), .DECK_SIZE(DECK_SIZE)) dut (
      .clk_ctrl_i    (clk_ctrl_i),
      .rst_ctrl_i    (rst_ctrl_i),
      .start_deal_i  (start_deal_i),
      .player_hit_i  (player_hit_i),
      .dealer_hit_i  (dealer_hit_i),
      .card_dp_i     (card_dp_i),
      .req_card_dp_o (req_card_dp_o),
      .card_o        (card_o),
      .card_valid_o  (card_valid_o),
      .card_dest_o   (card_dest_o),
      .player_ack_o  (player_ack_o),
      .dealer_ack_o  (dealer_ack_o),
      .busy_o        (busy_o),
      .deal_done_o   (deal_done_o),
      .deck_empty_o  (deck_empty_o)
   );

   // Deck stub: the card is valid only in the cycle CARD_LAT after the request.
   logic [7:0]          deck [8] = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd0, 8'd66, 8'd77, 8'd88};
   logic [2:0]          deck_idx = '0;
   logic [CARD_LAT-1:0] req_hist = '0;

   always @(negedge clk_ctrl_i) begin
      if (!rst_ctrl_i) begin
         deck_idx  = '0;
         req_hist  = '0;
         card_dp_i = 8'hEE;
      end else begin
         if (req_hist[CARD_LAT-1]) begin
            card_dp_i = deck[deck_idx];
            deck_idx  = deck_idx + 3'd1;
         end else begin
            card_dp_i = 8'hEE;
         end
         req_hist = {req_hist[CARD_LAT-2:0], req_card_dp_o};
      end
   end

   typedef struct {
      int         cyc;
      logic [7:0] card;
      logic       dest;
      logic       pack;
      logic       dack;
   } card_ev_t;

   card_ev_t val_q[$];
   int       req_q[$];
   int       done_q[$];
   int       cyc;
   int       ack_n;
   int       stray_n;
   int       empty_cyc;
   int       n_tests = 0;
   int       n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      val_q.delete();
      req_q.delete();
      done_q.delete();
      ack_n     = 0;
      stray_n   = 0;
      empty_cyc = -1;
   endtask

   task automatic step();
      card_ev_t ev;
      @(posedge clk_ctrl_i);
      #1;
      cyc++;
      if (req_card_dp_o) req_q.push_back(cyc);
      if (deal_done_o) done_q.push_back(cyc);
      if (deck_empty_o && empty_cyc < 0) empty_cyc = cyc;
      if (player_ack_o || dealer_ack_o) begin
         ack_n++;
         if (!card_valid_o) stray_n++;
      end
      if (card_valid_o) begin
         ev.cyc  = cyc;
         ev.card = card_o;
         ev.dest = card_dest_o;
         ev.pack = player_ack_o;
         ev.dack = dealer_ack_o;
         val_q.push_back(ev);
         $display("[TB] cyc %0d card %0d dest %0d pack %0b dack %0b done %0b empty %0b",
                  cyc, card_o, card_dest_o, player_ack_o, dealer_ack_o, deal_done_o, deck_empty_o);
      end
   endtask

   task automatic release_reset();
      @(posedge clk_ctrl_i);
      #1;
      rst_ctrl_i = 1'b1;
      cyc        = 0;
      clear_logs();
   endtask

   task automatic do_reset();
      start_deal_i = 1'b0;
      player_hit_i = 1'b0;
      dealer_hit_i = 1'b0;
      rst_ctrl_i   = 1'b0;
      release_reset();
   endtask

   task automatic check_card(input string tag, input int idx, input int exp_cyc,
                             input int exp_card, input logic [2:0] exp_flags);
      card_ev_t ev;
      if (idx >= val_q.size()) begin
         check_val({tag, "_present"}, 32'd0, 32'd1);
         return;
      end
      ev = val_q[idx];
      check_val({tag, "_cyc"}, ev.cyc, exp_cyc);
      check_val({tag, "_card"}, {24'd0, ev.card}, exp_card);
      check_val({tag, "_flags"}, {29'd0, ev.dest, ev.pack, ev.dack}, {29'd0, exp_flags});
   endtask

   function automatic int req_at(input int idx);
      return (idx < req_q.size()) ? req_q[idx] : -1;
   endfunction

   task automatic start_round_at5();
      repeat (5) step();
      start_deal_i = 1'b1;
      step();
      start_deal_i = 1'b0;
   endtask

   logic [2:0] init_flags [4] = '{3'b000, 3'b100, 3'b000, 3'b100};
   int         init_cards [4] = '{11, 22, 33, 44};

   initial begin
      // Asynchronous reset before any clock edge.
      #2 rst_ctrl_i = 1'b0;
      #1;
      check_val("rst_outputs", {19'd0, req_card_dp_o, card_o, card_valid_o, card_dest_o,
                                player_ack_o, dealer_ack_o, deal_done_o, deck_empty_o}, 32'd0);
      check_val("rst_busy", busy_o, 32'd0);
      release_reset();

      // A: initial deal timing, then start+hit together in READY -> new round exhausts deck.
      start_round_at5();
      while (cyc < 20) step();
      check_val("a_req_n", req_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("a_req%0d", i), req_at(i), 6 + 3 * i);
         check_card($sformatf("a_card%0d", i), i, 9 + 3 * i, init_cards[i], init_flags[i]);
      end
      check_val("a_done_n", done_q.size(), 1);
      check_val("a_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 18);
      check_val("a_busy_ready", busy_o, 0);
      clear_logs();
      start_deal_i = 1'b1;
      dealer_hit_i = 1'b1;
      step();
      start_deal_i = 1'b0;
      dealer_hit_i = 1'b0;
      while (cyc < 30) step();
      check_val("a2_req_n", req_q.size(), 2);
      check_val("a2_req0", req_at(0), 21);
      check_val("a2_req1", req_at(1), 24);
      check_card("a2_card0", 0, 24, 0, 3'b000);
      check_card("a2_card1", 1, 27, 66, 3'b100);
      check_val("a2_done_n", done_q.size(), 0);
      check_val("a2_acks", ack_n, 0);
      check_val("a2_empty_cyc", empty_cyc, 27);
      check_val("a2_busy", busy_o, 0);
      clear_logs();
      start_deal_i = 1'b1;
      step();
      start_deal_i = 1'b0;
      repeat (6) step();
      check_val("a3_no_req_empty", req_q.size(), 0);
      check_val("a3_empty_sticky", deck_empty_o, 1);

      // B: reset during INIT_WAIT of the 2nd card.
      do_reset();
      start_round_at5();
      while (cyc < 10) step();
      check_val("b_busy_pre", busy_o, 1);
      check_val("b_card_pre", card_o, 11);
      #2 rst_ctrl_i = 1'b0;
      #1;
      check_val("b_rst_card", card_o, 0);
      check_val("b_rst_flags", {24'd0, req_card_dp_o, card_valid_o, card_dest_o, player_ack_o,
                                dealer_ack_o, busy_o, deal_done_o, deck_empty_o}, 32'd0);
      release_reset();
      while (cyc < 12) step();
      check_val("b_no_valid", val_q.size(), 0);
      check_val("b_no_req", req_q.size(), 0);
      start_deal_i = 1'b1;
      step();
      start_deal_i = 1'b0;
      while (cyc < 27) step();
      check_val("b_req0", req_at(0), 13);
      check_card("b_card0", 0, 16, 11, 3'b000);
      check_card("b_card3", 3, 25, 44, 3'b100);
      check_val("b_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 25);

      // C: start during INIT_WAIT ignored; hit held during the deal served after deal_done.
      do_reset();
      start_round_at5();
      step();
      start_deal_i = 1'b1;
      player_hit_i = 1'b1;
      step();
      start_deal_i = 1'b0;
      while (cyc < 40) begin
         step();
         if (player_ack_o) player_hit_i = 1'b0;
      end
      check_val("c_req_n", req_q.size(), 5);
      check_val("c_req_hit", req_at(4), 19);
      check_val("c_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, 18);
      check_card("c_hit", 4, 22, 0, 3'b010);
      check_val("c_acks", ack_n, 1);
      check_val("c_stray", stray_n, 0);
      check_val("c_not_empty", deck_empty_o, 0);

      // D: simultaneous player/dealer hits for two grants.
      do_reset();
      start_round_at5();
      while (cyc < 20) step();
      player_hit_i = 1'b1;
      dealer_hit_i = 1'b1;
      while (cyc < 40) begin
         step();
         if (ack_n >= 2) begin
            player_hit_i = 1'b0;
            dealer_hit_i = 1'b0;
         end
      end
      check_card("d_tie1", 4, 24, 0, 3'b010);
      check_card("d_tie2", 5, 28, 66, TIE2_FLAGS);
      check_val("d_acks", ack_n, 2);
      check_val("d_empty_cyc", empty_cyc, 28);

      // E: player hit held for three requests with DECK_SIZE=6.
      do_reset();
      start_round_at5();
      while (cyc < 20) step();
      player_hit_i = 1'b1;
      while (cyc < 50) step();
      player_hit_i = 1'b0;
      check_val("e_acks", ack_n, 2);
      check_val("e_valid_n", val_q.size(), 6);
      check_val("e_req_n", req_q.size(), 6);
      check_val("e_req_last", req_at(5), 25);
      check_card("e_hit2", 5, 28, 66, 3'b010);
      check_val("e_empty_cyc", empty_cyc, 28);
      check_val("e_stray", stray_n, 0);
      check_val("e_busy", busy_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
